// File: rtl/mdu_pkg.sv
// Shared types for the MDU issue controller: opcodes, engine op codes, FSM states.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    localparam logic [1:0] ENG_IDLE = 2'b00;
    localparam logic [1:0] ENG_MUL  = 2'b01;
    localparam logic [1:0] ENG_DIV  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_op_decode.sv
// Combinational MDU opcode decode: engine ops vs. local HI/LO moves.
module mdu_op_decode
    import mdu_pkg::*;
(
    input  logic [3:0] op,
    output logic       is_eng,
    output logic [1:0] eng_op,
    output logic       sign,
    output logic       is_mt,
    output logic       is_mf,
    output logic       sel_hi
);

    always_comb begin
        is_eng = 1'b0;
        eng_op = ENG_IDLE;
        sign   = 1'b0;
        is_mt  = 1'b0;
        is_mf  = 1'b0;
        sel_hi = 1'b0;
        case (mdu_op_e'(op))
            MDU_MULT:  begin is_eng = 1'b1; eng_op = ENG_MUL; sign = 1'b1; end
            MDU_MULTU: begin is_eng = 1'b1; eng_op = ENG_MUL;              end
            MDU_DIV:   begin is_eng = 1'b1; eng_op = ENG_DIV; sign = 1'b1; end
            MDU_DIVU:  begin is_eng = 1'b1; eng_op = ENG_DIV;              end
            MDU_MTHI:  begin is_mt  = 1'b1; sel_hi = 1'b1;                 end
            MDU_MTLO:  begin is_mt  = 1'b1;                                end
            MDU_MFHI:  begin is_mf  = 1'b1; sel_hi = 1'b1;                 end
            MDU_MFLO:  begin is_mf  = 1'b1;                                end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU initiator: owns HI/LO, issues one engine request at a time.
// Optional MDU_DIV0_GUARD_EN drops divides by zero without engine traffic.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rt,
    input  logic             in_kill,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] req_src0,
    output logic [WIDTH-1:0] req_src1,
    output logic [1:0]       req_op,
    output logic             req_sign,
    output logic             req_valid,
    input  logic             req_ready,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [WIDTH-1:0] rsp_res0,
    input  logic [WIDTH-1:0] rsp_res1
);

    state_e     state;
    logic       is_eng, sign, is_mt, is_mf, sel_hi;
    logic [1:0] eng_op;
    logic       accept, div0_skip;

    mdu_op_decode u_dec (
        .op     (in_op),
        .is_eng (is_eng),
        .eng_op (eng_op),
        .sign   (sign),
        .is_mt  (is_mt),
        .is_mf  (is_mf),
        .sel_hi (sel_hi)
    );

    assign accept = in_valid & ~in_kill & ~busy;
    assign stall  = in_valid & (in_op != MDU_NONE) & busy;
    assign mf_data = is_mf ? (sel_hi ? hi : lo) : '0;

`ifdef MDU_DIV0_GUARD_EN
    assign div0_skip = (eng_op == ENG_DIV) && (in_rt == '0);
`else
    assign div0_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            hi        <= '0;
            lo        <= '0;
            req_src0  <= '0;
            req_src1  <= '0;
            req_op    <= ENG_IDLE;
            req_sign  <= 1'b0;
            req_valid <= 1'b0;
            rsp_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_eng && !div0_skip) begin
                        req_src0  <= in_rs;
                        req_src1  <= in_rt;
                        req_op    <= eng_op;
                        req_sign  <= sign;
                        req_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_REQ;
                    end else if (accept && is_mt) begin
                        if (sel_hi) hi <= in_rs;
                        else        lo <= in_rs;
                    end
                end
                S_REQ: begin
                    // rsp_ready stays low here, so an early rsp_valid is left for S_RSP
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        req_op    <= ENG_IDLE;
                        rsp_ready <= 1'b1;
                        state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_valid) begin
                        hi        <= rsp_res1;
                        lo        <= rsp_res0;
                        rsp_ready <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with an expected-HI/LO scoreboard.
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk, reset;
    logic         in_valid, in_kill;
    logic [3:0]   in_op;
    logic [W-1:0] in_rs, in_rt;
    logic [W-1:0] hi, lo, mf_data;
    logic         busy, stall;
    logic [W-1:0] req_src0, req_src1;
    logic [1:0]   req_op;
    logic         req_sign, req_valid, req_ready;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_res0, rsp_res1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_hi, m_lo, cur_rs, cur_rt;

    mdu_issue_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_kill(in_kill),
        .hi(hi), .lo(lo), .mf_data(mf_data), .busy(busy), .stall(stall),
        .req_src0(req_src0), .req_src1(req_src1), .req_op(req_op), .req_sign(req_sign),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res0(rsp_res0), .rsp_res1(rsp_res1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an engine op; expected HI/LO for its completion go to the scoreboard.
    task automatic start_op(input logic [3:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                            input logic [1:0] eop, input logic esign,
                            input logic [W-1:0] ehi, input logic [W-1:0] elo);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        sb.push_back(e);
        cur_rs = rs;
        cur_rt = rt;
        chk("busy_pre", 32'(busy), 32'd0);
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt;
        @(negedge clk);
        in_valid = 1'b0; in_op = MDU_NONE;
        chk("req_valid", 32'(req_valid), 32'd1);
        chk("req_op", 32'(req_op), 32'(eop));
        chk("req_sign", 32'(req_sign), 32'(esign));
        chk("req_src0", req_src0, rs);
        chk("req_src1", req_src1, rt);
        chk("busy_req", 32'(busy), 32'd1);
        chk("rsp_ready_req", 32'(rsp_ready), 32'd0);
    endtask

    // Hold req_ready low n cycles, then handshake.
    task automatic hold_req(input int n);
        req_ready = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("req_valid_hold", 32'(req_valid), 32'd1);
            chk("req_src0_hold", req_src0, cur_rs);
            chk("req_src1_hold", req_src1, cur_rt);
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        chk("req_valid_rsp", 32'(req_valid), 32'd0);
        chk("req_op_rsp", 32'(req_op), 32'(ENG_IDLE));
        chk("rsp_ready", 32'(rsp_ready), 32'd1);
        chk("busy_rsp", 32'(busy), 32'd1);
        chk("hi_rsp", hi, m_hi);
        chk("lo_rsp", lo, m_lo);
    endtask

    task automatic respond(input logic [W-1:0] r0, input logic [W-1:0] r1, input int delay);
        exp_t e;
        repeat (delay) begin
            @(negedge clk);
            chk("rsp_ready_wait", 32'(rsp_ready), 32'd1);
            chk("busy_wait", 32'(busy), 32'd1);
        end
        rsp_valid = 1'b1; rsp_res0 = r0; rsp_res1 = r1;
        @(negedge clk);
        rsp_valid = 1'b0;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            m_hi = e.hi;
            m_lo = e.lo;
            chk("hi_done", hi, e.hi);
            chk("lo_done", lo, e.lo);
        end
        chk("busy_done", 32'(busy), 32'd0);
        chk("rsp_ready_done", 32'(rsp_ready), 32'd0);
        chk("req_valid_done", 32'(req_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = MDU_NONE; in_rs = '0; in_rt = '0; in_kill = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_res0 = '0; rsp_res1 = '0;
        m_hi = '0; m_lo = '0; cur_rs = '0; cur_rt = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_op", 32'(req_op), 32'(ENG_IDLE));
        chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        chk("rst_mf_data", mf_data, 32'd0);

        // MULT signed
        start_op(MDU_MULT, 32'hFFFFFFFF, 32'd2, ENG_MUL, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE);
        hold_req(0);
        respond(32'hFFFFFFFE, 32'hFFFFFFFF, 1);

        // MULTU back-to-back in the first idle cycle
        start_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, ENG_MUL, 1'b0, 32'h00000001, 32'hFFFFFFFE);
        hold_req(0);
        respond(32'hFFFFFFFE, 32'h00000001, 0);

        // DIV with req_ready stalled; a stray rsp_valid during S_REQ must not be consumed
        start_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, ENG_DIV, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        rsp_valid = 1'b1; rsp_res0 = 32'hBAD0BAD0; rsp_res1 = 32'hBAD1BAD1;
        hold_req(3);
        respond(32'hFFFFFFFD, 32'hFFFFFFFF, 2);

        // MTHI / MFHI / MTLO / MFLO
        in_valid = 1'b1; in_op = MDU_MTHI; in_rs = 32'h00001234;
        @(negedge clk);
        m_hi = 32'h00001234;
        chk("mthi_hi", hi, m_hi);
        chk("mthi_req_valid", 32'(req_valid), 32'd0);
        chk("mthi_busy", 32'(busy), 32'd0);
        in_op = MDU_MFHI; #1;
        chk("mfhi_data", mf_data, 32'h00001234);
        chk("mfhi_stall", 32'(stall), 32'd0);
        @(negedge clk);
        in_op = MDU_MTLO; in_rs = 32'h00005678;
        @(negedge clk);
        m_lo = 32'h00005678;
        chk("mtlo_lo", lo, m_lo);
        chk("mtlo_hi_kept", hi, m_hi);
        in_op = MDU_MFLO; #1;
        chk("mflo_data", mf_data, 32'h00005678);
        in_valid = 1'b0; in_op = MDU_NONE; #1;
        chk("mf_none", mf_data, 32'd0);

        // in_kill suppresses accept
        @(negedge clk);
        in_valid = 1'b1; in_kill = 1'b1; in_op = MDU_MULT; in_rs = 32'd3; in_rt = 32'd4;
        @(negedge clk);
        chk("kill_req_valid", 32'(req_valid), 32'd0);
        chk("kill_busy", 32'(busy), 32'd0);
        in_op = MDU_MTLO; in_rs = 32'hBADBAD00;
        @(negedge clk);
        chk("kill_lo", lo, m_lo);
        chk("kill_hi", hi, m_hi);
        in_valid = 1'b0; in_kill = 1'b0; in_op = MDU_NONE;

        // stall while busy; MTHI presented during S_REQ must be ignored
        start_op(MDU_DIVU, 32'd100, 32'd7, ENG_DIV, 1'b0, 32'd2, 32'd14);
        in_valid = 1'b1; in_op = MDU_MTHI; in_rs = 32'hDEADBEEF; #1;
        chk("stall_req", 32'(stall), 32'd1);
        hold_req(1);
        in_op = MDU_MFLO; in_kill = 1'b1; #1;
        chk("stall_rsp", 32'(stall), 32'd1);
        chk("mflo_busy_data", mf_data, 32'h00005678);
        in_kill = 1'b0;
        respond(32'd14, 32'd2, 1);
        #1;
        chk("stall_released", 32'(stall), 32'd0);
        chk("mflo_after", mf_data, 32'd14);
        in_valid = 1'b0; in_op = MDU_NONE;
        @(negedge clk);

        // reset in S_RSP
        start_op(MDU_MULT, 32'd3, 32'd5, ENG_MUL, 1'b1, 32'd0, 32'd15);
        hold_req(0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_hi = '0; m_lo = '0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req_valid", 32'(req_valid), 32'd0);
        chk("midrst_rsp_ready", 32'(rsp_ready), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);

        // divide by zero
        in_valid = 1'b1; in_op = MDU_MTHI; in_rs = 32'd11;
        @(negedge clk);
        in_op = MDU_MTLO; in_rs = 32'd22;
        @(negedge clk);
        in_valid = 1'b0; in_op = MDU_NONE;
        m_hi = 32'd11; m_lo = 32'd22;
`ifdef MDU_DIV0_GUARD_EN
        in_valid = 1'b1; in_op = MDU_DIVU; in_rs = 32'd9; in_rt = 32'd0;
        @(negedge clk);
        in_valid = 1'b0; in_op = MDU_NONE;
        chk("div0_req_valid", 32'(req_valid), 32'd0);
        chk("div0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("div0_req_valid2", 32'(req_valid), 32'd0);
        chk("div0_hi", hi, 32'd11);
        chk("div0_lo", lo, 32'd22);
`else
        start_op(MDU_DIVU, 32'd9, 32'd0, ENG_DIV, 1'b0, 32'd9, 32'hFFFFFFFF);
        hold_req(0);
        respond(32'hFFFFFFFF, 32'd9, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Pipeline-side initiator for the multiply/divide engine's valid/ready protocol. The engine takes src0, src1, op and sign, and returns res0 (low word or quotient) and res1 (high word or remainder).
- Sits in the E stage. It decodes MDU instructions, owns the architectural HI/LO registers, and issues one request at a time to the engine. It accepts the response and raises busy/stall toward the hazard unit.
- mthi, mtlo, mfhi and mflo are handled locally and never reach the engine.

Parameters:
- WIDTH, 32, operand/result word width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  E-stage instruction is a live MDU op
- in_op  in  4  MDU opcode (package enum)
- in_rs  in  WIDTH  rs operand
- in_rt  in  WIDTH  rt operand
- in_kill  in  1  squash E-stage op this cycle (exception/flush)
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO
- mf_data  out  WIDTH  hi for MFHI, lo for MFLO, else 0
- busy  out  1  engine transaction outstanding
- stall  out  1  in_valid & (in_op != MDU_NONE) & busy
- req_src0  out  WIDTH  to engine
- req_src1  out  WIDTH  to engine
- req_op  out  2  00 IDLE, 01 MUL, 10 DIV
- req_sign  out  1  signed operation
- req_valid  out  1  request valid
- req_ready  in  1  engine accepts request
- rsp_valid  in  1  engine result valid
- rsp_ready  out  1  controller accepts result
- rsp_res0  in  WIDTH  low/quotient
- rsp_res1  in  WIDTH  high/remainder

Behaviour:
- Reset (synchronous, active-high, overrides everything): state=S_IDLE, hi=lo=0, operand regs=0, req_valid=0, req_op=IDLE, rsp_ready=0, busy=0.
- Accept condition: accept = in_valid & ~in_kill & ~busy.
- States:
  - S_IDLE: on accept with MULT/MULTU/DIV/DIVU, register src0=rs, src1=rt, op, sign, then go to S_REQ.
  - S_REQ: req_valid=1. On req_valid&req_ready, go to S_RSP.
  - S_RSP: rsp_ready=1. On rsp_valid&rsp_ready, hi<=res1, lo<=res0, go to S_IDLE.
- Sign encoding: MULT and DIV set sign=1; MULTU and DIVU set sign=0.
- Outputs are registered and stable while in S_REQ: req_valid, req_src0, req_src1, req_op, req_sign. req_op=IDLE outside S_REQ.
- busy is 1 in S_REQ and S_RSP and 0 in S_IDLE. It is registered, so busy rises the cycle after accept.
- Minimum latency, accept to new hi/lo visible: 1 cycle to S_REQ, plus 1 cycle if req_ready=1, plus the engine's response latency. hi/lo update on the response handshake edge; busy=0 in the following cycle.
- rsp_ready is asserted only in S_RSP. A rsp_valid outside S_RSP is ignored. In S_REQ, a rsp_valid in the same cycle as the req handshake is not consumed.
- MTHI/MTLO:
  - On accept in S_IDLE, hi<=rs or lo<=rs at the edge. No engine traffic, busy stays 0.
  - While busy they are not accepted; stall is asserted.
- MFHI/MFLO: mf_data is combinational from the current hi/lo. It is not gated by kill, and stall is asserted if busy.
- in_kill: suppresses accept that cycle, with no state or HI/LO change. It has no effect once a transaction is in S_REQ or S_RSP; the outstanding operation completes and writes HI/LO.
- Back-to-back operation: a new op may be accepted in the first cycle busy=0. Same-cycle write of hi/lo plus a new accept cannot occur, because accept requires ~busy.
- Ops accepted while busy: in_op with in_valid while busy is never accepted; stall=1 holds the pipeline.
- Reset mid-transaction: returns to S_IDLE immediately and drops req_valid/rsp_ready. The engine is reset on the same reset.

Optional Feature:
- MDU_DIV0_GUARD_EN defined:
  - DIV/DIVU with rt==0 is accepted but never issued to the engine.
  - State stays S_IDLE, hi/lo are unchanged, busy stays 0.
- Undefined: a zero divisor is issued normally and hi/lo take whatever the engine returns.

Decomposition:
- Package mdu_pkg:
  - opcode enum MDU_NONE=0, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO
  - engine op constants ENG_IDLE=2'b00, ENG_MUL=2'b01, ENG_DIV=2'b10
  - state enum S_IDLE, S_REQ, S_RSP
- Sub-module mdu_op_decode, combinational: in_op -> is_eng, eng_op, sign, is_mt, is_mf, sel_hi.

Test Plan:
- MULT rs=32'hFFFFFFFF, rt=2, req_ready=1 -> req_op=01, req_sign=1. After response res1=FFFFFFFF, res0=FFFFFFFE: hi=FFFFFFFF, lo=FFFFFFFE, busy high for exactly the transaction.
- MULTU same operands, engine returns 1/FFFFFFFE -> hi=00000001, lo=FFFFFFFE, req_sign=0.
- DIV rs=-7, rt=2, req_ready low 3 cycles -> req_valid/req_src0/req_src1 stable for 3 cycles. Response res0=FFFFFFFD, res1=FFFFFFFF -> lo=FFFFFFFD, hi=FFFFFFFF.
- MTHI rs=1234 then MFHI -> hi=00001234 next cycle, mf_data=00001234, no req_valid.
- MFLO while in S_RSP -> stall=1 until busy falls; in_kill with MULT in S_IDLE -> no req_valid, hi/lo unchanged.
- Reset asserted in S_RSP -> next cycle busy=0, req_valid=0, hi=lo=0. Under MDU_DIV0_GUARD_EN, DIVU rt=0 -> no req_valid, hi/lo unchanged.
